// File: rtl/bootloader_pkg.sv
// Shared CPU package: bootloader state encoding, memory geometry and
// handshake helpers used by the bootloader and the control unit.
package bootloader_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned MEM_DEPTH  = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    function automatic logic accepts_bytes(input logic [2:0] s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
    endfunction

    function automatic logic holds_cpu(input logic [2:0] s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/bootloader_if.sv
// Bootloader bus bundle: inbound byte stream plus program-memory write port.
// master = bootloader side, slave = byte source / memory side.
interface bootloader_if
    import bootloader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );

endinterface

// File: rtl/bootloader.sv
// Serial program loader: length byte, N data bytes written to program memory.
// Optional trailing checksum byte enabled by BOOTLOADER_CHECKSUM_EN.
module bootloader
    import bootloader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         slowclk,
    input  logic         reset,
    input  logic         start,
    bootloader_if.master bus,
    output logic         Bootload,
    output logic         done,
    output logic         err
);

    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

`ifdef BOOTLOADER_CHECKSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CHK;
`else
    localparam logic [2:0] S_AFTER_DATA = S_FIN;
`endif

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              last_byte;
    logic [ADDR_W:0]   len_in;

`ifdef BOOTLOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_byte = (cnt_q + CNT_ONE) == len_q;

    // A zero length field encodes a full memory image.
    assign len_in = (bus.in_data[ADDR_W-1:0] == '0)
                  ? CNT_FULL
                  : {1'b0, bus.in_data[ADDR_W-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef BOOTLOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
`ifdef BOOTLOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d   = len_in;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.in_data;
                    cnt_d   = cnt_q + CNT_ONE;
`ifdef BOOTLOADER_CHECKSUM_EN
                    sum_d   = sum_q + bus.in_data;
`endif
                    if (last_byte) begin
                        state_d = S_AFTER_DATA;
                    end
                end
            end
`ifdef BOOTLOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    state_d = (bus.in_data == sum_q) ? S_FIN : S_ERR;
                end
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
`endif
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef BOOTLOADER_CHECKSUM_EN
    always_ff @(posedge slowclk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign err = (state_q == S_ERR);
`else
    assign err = 1'b0;
`endif

    assign bus.in_ready  = accepts_bytes(state_q);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign Bootload      = holds_cpu(state_q);
    assign done          = (state_q == S_FIN);

endmodule

// File: tb/tb_bootloader.sv
// Scoreboard bench for bootloader: random sessions plus directed loads,
// length-0, stalls, mid-session reset and (optionally) checksum cases.
module tb_bootloader;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic slowclk = 1'b0;
    logic reset;
    logic start;
    logic Bootload;
    logic done;
    logic err;

    bootloader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bootloader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .slowclk (slowclk),
        .reset   (reset),
        .start   (start),
        .bus     (bus),
        .Bootload(Bootload),
        .done    (done),
        .err     (err)
    );

    always #5 slowclk = ~slowclk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    int         done_pending = 0;
    bit         prev_done = 0;
    bit         err_seen = 0;
    wr_t        mon_e;
    logic [7:0] dq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every write and done pulse is matched against the model queues.
    always @(negedge slowclk) begin
        if (!reset) begin
            if (err) err_seen = 1'b1;
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", bus.mem_we, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", bus.mem_addr, mon_e.a);
                    chk("wr_data", bus.mem_wdata, mon_e.d);
                end
            end
            if (done) begin
                if (done_pending == 0) chk("unexpected_done", done, 0);
                else begin
                    done_pending--;
                    chk("done_expected", done, 1);
                end
            end
            if (prev_done) chk("done_one_cycle", done, 0);
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    function automatic int pick(input int fstall);
        return (fstall < 0) ? int'($urandom_range(0, 3)) : fstall;
    endfunction

    task automatic send(input logic [7:0] b, input int stall);
        bus.in_valid = 1'b0;
        repeat (stall) @(negedge slowclk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (bus.in_ready) begin
                @(negedge slowclk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                return;
            end
            @(negedge slowclk);
        end
        chk("send_timeout", bus.in_ready, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge slowclk);
        start = 1'b0;
    endtask

    task automatic fill(input int n);
        dq.delete();
        repeat (n) dq.push_back(8'($urandom));
    endtask

    // cs_sel: -2 correct checksum, -1 random good/bad, else literal byte.
    task automatic session(input logic [7:0] lenb, input int fstall,
                           input int cs_sel);
        int         n;
        logic [7:0] sum;
        logic [7:0] cs;
        bit         good;
        wr_t        e;
        n   = (lenb[4:0] == 5'd0) ? DEPTH : int'(lenb[4:0]);
        sum = 8'h00;
        do_start();
        chk("bootload_hi", Bootload, 1);
        chk("err_clear", err, 0);
        chk("ready_len", bus.in_ready, 1);
        send(lenb, pick(fstall));
        for (int i = 0; i < n; i++) begin
            e.a = AW'(i);
            e.d = dq[i];
            exp_q.push_back(e);
            sum = sum + dq[i];
`ifndef BOOTLOADER_CHECKSUM_EN
            if (i == n - 1) done_pending++;
`endif
            send(dq[i], pick(fstall));
        end
        chk("last_we", bus.mem_we, 1);
`ifdef BOOTLOADER_CHECKSUM_EN
        chk("no_done_in_chk", done, 0);
        if (cs_sel == -2) cs = sum;
        else if (cs_sel == -1)
            cs = ($urandom_range(0, 1) == 1) ? sum
               : sum ^ 8'($urandom_range(1, 255));
        else cs = 8'(cs_sel);
        good = (cs == sum);
        if (good) done_pending++;
        send(cs, pick(fstall));
        if (!good) begin
            chk("err_set", err, 1);
            chk("bootload_err", Bootload, 1);
            bus.in_valid = 1'b1;
            repeat (4) @(negedge slowclk);
            chk("err_hold", err, 1);
            chk("bootload_hold", Bootload, 1);
            chk("ready_err", bus.in_ready, 0);
            bus.in_valid = 1'b0;
            return;
        end
`else
        good = (cs_sel != 12345);
        cs   = sum;
`endif
        chk("done_pulse", done, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        chk("ready_fin", bus.in_ready, 0);
        @(negedge slowclk);
        chk("bootload_fall", Bootload, 0);
        chk("ready_idle", bus.in_ready, 0);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lb;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge slowclk);
        chk("rst_bootload", Bootload, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_ready", bus.in_ready, 0);
        reset = 1'b0;
        @(negedge slowclk);

        dq = '{8'h21, 8'h42, 8'h80};
        session(8'h03, 0, -2);

        fill(DEPTH);
        session(8'h00, -1, -2);

        fill(4);
        session(8'h04, 2, -2);

`ifdef BOOTLOADER_CHECKSUM_EN
        dq = '{8'hF0, 8'h20};
        session(8'h02, 0, 8'h10);
        session(8'h02, 0, 8'h11);
`endif

        repeat (8) begin
            lb = 8'($urandom);
            fill((lb[4:0] == 5'd0) ? DEPTH : int'(lb[4:0]));
            session(lb, -1, -1);
        end

        fill(5);
        do_start();
        send(8'h05, 0);
        for (int i = 0; i < 3; i++) begin
            mon_e.a = AW'(i);
            mon_e.d = dq[i];
            exp_q.push_back(mon_e);
            send(dq[i], 0);
        end
        @(negedge slowclk);
        chk("mid_bootload_pre", Bootload, 1);
        reset = 1'b1;
        #1;
        chk("mid_bootload", Bootload, 0);
        chk("mid_we", bus.mem_we, 0);
        chk("mid_addr", bus.mem_addr, 0);
        chk("mid_wdata", bus.mem_wdata, 0);
        chk("mid_ready", bus.in_ready, 0);
        @(negedge slowclk);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = dq[3];
        repeat (4) @(negedge slowclk);
        chk("post_rst_ready", bus.in_ready, 0);
        chk("post_rst_bootload", Bootload, 0);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge slowclk);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_pending", done_pending, 0);
`ifndef BOOTLOADER_CHECKSUM_EN
        chk("err_tied_low", err_seen, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
